// File: rtl/tt_vmem_sb_pkg.sv
// Shared types and default sizing for the OVI vector-memory scoreboard.
// sb_entry_t carries the per-entry control flags and destination register.
// The counter, lqid and result fields live in separately parameterised
// arrays in the top, because their widths follow the module parameters.
package tt_vmem_sb_pkg;

  localparam int SB_ENTRIES_DEF = 32;
  localparam int LQ_DEPTH_DEF   = 8;
  localparam int REF_W_DEF      = 4;
  localparam int RD_W_DEF       = 64;
  localparam int VD_W           = 5;
  localparam int FFLAGS_W       = 5;

  typedef struct packed {
    logic            valid;
    logic            is_load;
    logic            got_last;
    logic            got_sync_end;
    logic            drained;
    logic [VD_W-1:0] vd;
  } sb_entry_t;

endpackage

// File: rtl/tt_rr_arb.sv
// Round-robin arbiter with grant hold.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   i_flush        - return pointer to 0 and drop any held grant
//   i_req          - request vector
//   i_adv          - grant accepted this cycle; pointer moves past it
//   o_gnt_valid    - some request is granted
//   o_gnt          - one-hot grant
//   o_gnt_idx      - encoded grant
// The search starts at the entry after the last accepted grant. A grant
// that is offered but not accepted is held next cycle (as long as its
// request is still up) so newly arriving requests cannot pre-empt it.
module tt_rr_arb #(
  parameter int WIDTH = 4,
  localparam int IW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_req,
  input  logic             i_adv,
  output logic             o_gnt_valid,
  output logic [WIDTH-1:0] o_gnt,
  output logic [IW-1:0]    o_gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    idx        = ptr_q;
    for (int i = 0; i < WIDTH; i++) begin
      // WIDTH is a power of two, so the IW-bit add wraps around the ring
      idx = ptr_q + IW'(i);
      if (!pick_found && i_req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end

    if (lock_q && i_req[lock_idx_q]) begin
      o_gnt_valid = 1'b1;
      o_gnt_idx   = lock_idx_q;
    end else begin
      o_gnt_valid = pick_found;
      o_gnt_idx   = pick_idx;
    end

    o_gnt = '0;
    if (o_gnt_valid) o_gnt[o_gnt_idx] = 1'b1;

    ptr_d      = ptr_q;
    lock_d     = o_gnt_valid && !i_adv;
    lock_idx_d = o_gnt_idx;
    if (o_gnt_valid && i_adv) ptr_d = o_gnt_idx + 1'b1;
    if (i_flush) begin
      ptr_d  = '0;
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/tt_vmem_scoreboard_ovi.sv
// Vector-memory scoreboard for the OVI vector path.
// Tracks in-flight vector memory instructions by sb_id, maps LQ slots back
// to their owning sb_id, requests load-buffer drains and retires entries
// once all of their LQ references have committed.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   i_alloc_*             - LQ slot allocation (first/last mark instruction)
//   i_sync_end_*          - memop sync-end for an entry
//   i_lq_commit_*         - an LQ slot committed (drops one reference)
//   i_rd_*, i_fflags      - scalar result / flags, addressed by LQ slot
//   i_flush               - kill all entries
//   i_lookup_sb_id/o_lookup_* - combinational entry read
//   o_drain_* / i_drain_ready - drain request, valid/ready
//   o_cmpl_*  / i_cmpl_ready  - completion, valid/ready
//   o_err                 - sticky protocol error
module tt_vmem_scoreboard_ovi
  import tt_vmem_sb_pkg::*;
#(
  parameter int SB_ENTRIES = SB_ENTRIES_DEF,
  parameter int LQ_DEPTH   = LQ_DEPTH_DEF,
  parameter int REF_W      = REF_W_DEF,
  parameter int RD_W       = RD_W_DEF,
  localparam int SB_W      = $clog2(SB_ENTRIES),
  localparam int LQ_W      = $clog2(LQ_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_alloc_valid,
  input  logic [SB_W-1:0]     i_alloc_sb_id,
  input  logic [LQ_W-1:0]     i_alloc_lqid,
  input  logic                i_alloc_first,
  input  logic                i_alloc_last,
  input  logic                i_alloc_is_load,
  input  logic [4:0]          i_alloc_vd,
  input  logic                i_sync_end_valid,
  input  logic [SB_W-1:0]     i_sync_end_sb_id,
  input  logic                i_lq_commit_valid,
  input  logic [LQ_W-1:0]     i_lq_commit_lqid,
  input  logic                i_rd_valid,
  input  logic [LQ_W-1:0]     i_rd_lqid,
  input  logic [RD_W-1:0]     i_rd,
  input  logic [4:0]          i_fflags,
  input  logic                i_flush,
  input  logic [SB_W-1:0]     i_lookup_sb_id,
  output logic [4:0]          o_lookup_vd,
  output logic [LQ_W-1:0]     o_lookup_lqid,
  output logic                o_drain_valid,
  input  logic                i_drain_ready,
  output logic [SB_W-1:0]     o_drain_sb_id,
  output logic [REF_W-1:0]    o_drain_ref_count,
  output logic [LQ_W-1:0]     o_drain_lqid_start,
  output logic                o_cmpl_valid,
  input  logic                i_cmpl_ready,
  output logic [SB_W-1:0]     o_cmpl_sb_id,
  output logic [RD_W-1:0]     o_cmpl_rd,
  output logic [4:0]          o_cmpl_fflags,
  output logic                o_err
);

  localparam logic [REF_W-1:0] REF_MAX = '1;

  sb_entry_t [SB_ENTRIES-1:0]            ent_q, ent_d;
  logic [SB_ENTRIES-1:0][REF_W-1:0]      ref_q, ref_d;
  logic [SB_ENTRIES-1:0][LQ_W-1:0]       lqs_q, lqs_d;
  logic [SB_ENTRIES-1:0][RD_W-1:0]       rd_q, rd_d;
  logic [SB_ENTRIES-1:0][FFLAGS_W-1:0]   ff_q, ff_d;
  logic [LQ_DEPTH-1:0][SB_W-1:0]         map_q, map_d;
  logic                                  err_q, err_d;

  logic [SB_ENTRIES-1:0] drain_req, cmpl_req, drain_gnt, cmpl_gnt;
  logic                  drain_vld, cmpl_vld, drain_fire, cmpl_fire;
  logic [SB_W-1:0]       drain_idx, cmpl_idx;

  logic [SB_W-1:0]  cmt_sb, res_sb;
  logic             inc, dec, err_set;
  logic [REF_W-1:0] base;

  // ---------------------------------------------------------------------
  // Eligibility, from registered state only
  // ---------------------------------------------------------------------
  always_comb begin
    for (int e = 0; e < SB_ENTRIES; e++) begin
      drain_req[e] = ent_q[e].valid && ent_q[e].is_load && ent_q[e].got_sync_end &&
                     ent_q[e].got_last && !ent_q[e].drained;
      cmpl_req[e]  = ent_q[e].valid && (ref_q[e] == '0) && ent_q[e].got_sync_end &&
                     ent_q[e].got_last;
    end
  end

  assign drain_fire = drain_vld && i_drain_ready;
  assign cmpl_fire  = cmpl_vld && i_cmpl_ready;

  tt_rr_arb #(.WIDTH(SB_ENTRIES)) u_drain_arb (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (i_flush),
    .i_req       (drain_req),
    .i_adv       (drain_fire),
    .o_gnt_valid (drain_vld),
    .o_gnt       (drain_gnt),
    .o_gnt_idx   (drain_idx)
  );

  tt_rr_arb #(.WIDTH(SB_ENTRIES)) u_cmpl_arb (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (i_flush),
    .i_req       (cmpl_req),
    .i_adv       (cmpl_fire),
    .o_gnt_valid (cmpl_vld),
    .o_gnt       (cmpl_gnt),
    .o_gnt_idx   (cmpl_idx)
  );

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    ent_d   = ent_q;
    ref_d   = ref_q;
    lqs_d   = lqs_q;
    rd_d    = rd_q;
    ff_d    = ff_q;
    map_d   = map_q;
    err_d   = err_q;
    err_set = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    base    = '0;
    // Commit and result use the slot owner before any same-cycle remap
    cmt_sb  = map_q[i_lq_commit_lqid];
    res_sb  = map_q[i_rd_lqid];

    if (i_flush) begin
      // Flush overrides everything else this cycle; lq_map is left as is
      for (int e = 0; e < SB_ENTRIES; e++) ent_d[e].valid = 1'b0;
    end else begin
      for (int e = 0; e < SB_ENTRIES; e++) begin
        if (drain_fire && drain_gnt[e]) ent_d[e].drained = 1'b1;
        if (cmpl_fire && cmpl_gnt[e])   ent_d[e].valid   = 1'b0;
      end

      if (i_sync_end_valid) ent_d[i_sync_end_sb_id].got_sync_end = 1'b1;

      // Allocation is applied after the handshakes so a first allocation
      // to an entry retiring this same cycle re-opens it.
      if (i_alloc_valid) begin
        map_d[i_alloc_lqid] = i_alloc_sb_id;
        if (i_alloc_first) begin
          if (ent_q[i_alloc_sb_id].valid) err_set = 1'b1;
          ent_d[i_alloc_sb_id].valid        = 1'b1;
          ent_d[i_alloc_sb_id].is_load      = i_alloc_is_load;
          ent_d[i_alloc_sb_id].got_last     = i_alloc_last;
          ent_d[i_alloc_sb_id].got_sync_end = i_sync_end_valid &&
                                              (i_sync_end_sb_id == i_alloc_sb_id);
          ent_d[i_alloc_sb_id].drained      = 1'b0;
          ent_d[i_alloc_sb_id].vd           = i_alloc_vd;
          lqs_d[i_alloc_sb_id]              = i_alloc_lqid;
          rd_d[i_alloc_sb_id]               = '0;
          ff_d[i_alloc_sb_id]               = '0;
        end else if (i_alloc_last) begin
          ent_d[i_alloc_sb_id].got_last     = 1'b1;
        end
      end

      // Reference count: a first allocation restarts from 0 before its +1;
      // an increment and decrement together cancel.
      for (int e = 0; e < SB_ENTRIES; e++) begin
        inc  = i_alloc_valid && (i_alloc_sb_id == SB_W'(e));
        dec  = i_lq_commit_valid && (cmt_sb == SB_W'(e));
        base = (inc && i_alloc_first) ? '0 : ref_q[e];
        if (inc && !dec) begin
          if (base == REF_MAX) err_set = 1'b1;
          else                 base    = base + 1'b1;
        end else if (dec && !inc) begin
          if (base == '0) err_set = 1'b1;
          else            base    = base - 1'b1;
        end
        ref_d[e] = base;
      end

      if (i_rd_valid) begin
        rd_d[res_sb] = i_rd;
        ff_d[res_sb] = i_fflags;
      end

      if (err_set) err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q <= '0;
      ref_q <= '0;
      lqs_q <= '0;
      map_q <= '0;
      err_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      ref_q <= ref_d;
      lqs_q <= lqs_d;
      map_q <= map_d;
      err_q <= err_d;
    end
  end

  // Result payload is only observable through a valid entry, which a
  // first allocation always initialises.
  always_ff @(posedge clk) begin
    rd_q <= rd_d;
    ff_q <= ff_d;
  end

  // ---------------------------------------------------------------------
  // Outputs, zeroed when not valid so reset drives every output to 0
  // ---------------------------------------------------------------------
  assign o_lookup_vd        = ent_q[i_lookup_sb_id].valid ? ent_q[i_lookup_sb_id].vd : '0;
  assign o_lookup_lqid      = ent_q[i_lookup_sb_id].valid ? lqs_q[i_lookup_sb_id]    : '0;
  assign o_drain_valid      = drain_vld;
  assign o_drain_sb_id      = drain_vld ? drain_idx        : '0;
  assign o_drain_ref_count  = drain_vld ? ref_q[drain_idx] : '0;
  assign o_drain_lqid_start = drain_vld ? lqs_q[drain_idx] : '0;
  assign o_cmpl_valid       = cmpl_vld;
  assign o_cmpl_sb_id       = cmpl_vld ? cmpl_idx       : '0;
  assign o_cmpl_rd          = cmpl_vld ? rd_q[cmpl_idx] : '0;
  assign o_cmpl_fflags      = cmpl_vld ? ff_q[cmpl_idx] : '0;
  assign o_err              = err_q;

endmodule

// File: tb/tb_tt_vmem_scoreboard_ovi.sv
module tb_tt_vmem_scoreboard_ovi;

  localparam int N     = 8;
  localparam int LQD   = 8;
  localparam int REFW  = 3;
  localparam int RDW   = 64;
  localparam int SBW   = 3;
  localparam int LQW   = 3;
  localparam int MAXREF = (1 << REFW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic i_alloc_valid, i_alloc_first, i_alloc_last, i_alloc_is_load;
  logic [SBW-1:0] i_alloc_sb_id, i_sync_end_sb_id, i_lookup_sb_id;
  logic [LQW-1:0] i_alloc_lqid, i_lq_commit_lqid, i_rd_lqid;
  logic [4:0] i_alloc_vd, i_fflags;
  logic i_sync_end_valid, i_lq_commit_valid, i_rd_valid, i_flush;
  logic [RDW-1:0] i_rd;
  logic i_drain_ready, i_cmpl_ready;
  logic [4:0] o_lookup_vd, o_cmpl_fflags;
  logic [LQW-1:0] o_lookup_lqid, o_drain_lqid_start;
  logic o_drain_valid, o_cmpl_valid, o_err;
  logic [SBW-1:0] o_drain_sb_id, o_cmpl_sb_id;
  logic [REFW-1:0] o_drain_ref_count;
  logic [RDW-1:0] o_cmpl_rd;

  always #5 clk = ~clk;

  tt_vmem_scoreboard_ovi #(.SB_ENTRIES(N), .LQ_DEPTH(LQD), .REF_W(REFW), .RD_W(RDW)) dut (
    .clk(clk), .reset(reset),
    .i_alloc_valid(i_alloc_valid), .i_alloc_sb_id(i_alloc_sb_id), .i_alloc_lqid(i_alloc_lqid),
    .i_alloc_first(i_alloc_first), .i_alloc_last(i_alloc_last), .i_alloc_is_load(i_alloc_is_load),
    .i_alloc_vd(i_alloc_vd), .i_sync_end_valid(i_sync_end_valid), .i_sync_end_sb_id(i_sync_end_sb_id),
    .i_lq_commit_valid(i_lq_commit_valid), .i_lq_commit_lqid(i_lq_commit_lqid),
    .i_rd_valid(i_rd_valid), .i_rd_lqid(i_rd_lqid), .i_rd(i_rd), .i_fflags(i_fflags),
    .i_flush(i_flush), .i_lookup_sb_id(i_lookup_sb_id), .o_lookup_vd(o_lookup_vd),
    .o_lookup_lqid(o_lookup_lqid), .o_drain_valid(o_drain_valid), .i_drain_ready(i_drain_ready),
    .o_drain_sb_id(o_drain_sb_id), .o_drain_ref_count(o_drain_ref_count),
    .o_drain_lqid_start(o_drain_lqid_start), .o_cmpl_valid(o_cmpl_valid), .i_cmpl_ready(i_cmpl_ready),
    .o_cmpl_sb_id(o_cmpl_sb_id), .o_cmpl_rd(o_cmpl_rd), .o_cmpl_fflags(o_cmpl_fflags), .o_err(o_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_valid[N], m_load[N], m_last[N], m_sync[N], m_drained[N];
  int m_ref[N], m_lqs[N], m_vd[N], m_ff[N];
  logic [63:0] m_rd[N];
  int m_map[LQD];
  bit m_err;
  int dptr, cptr, dhold, chold;
  bit dhold_v, chold_v;
  int e_d, e_c;

  task automatic model_reset();
    for (int e = 0; e < N; e++) begin
      m_valid[e] = 0; m_ref[e] = 0; m_lqs[e] = 0;
    end
    for (int l = 0; l < LQD; l++) m_map[l] = 0;
    m_err = 0; dptr = 0; cptr = 0; dhold_v = 0; chold_v = 0; dhold = 0; chold = 0;
  endtask

  function automatic int pick(input bit el[N], input int ptr, input bit hv, input int h);
    if (hv && el[h]) return h;
    for (int i = 0; i < N; i++) if (el[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic idle();
    i_alloc_valid = 0; i_alloc_sb_id = '0; i_alloc_lqid = '0; i_alloc_first = 0;
    i_alloc_last = 0; i_alloc_is_load = 0; i_alloc_vd = '0;
    i_sync_end_valid = 0; i_sync_end_sb_id = '0;
    i_lq_commit_valid = 0; i_lq_commit_lqid = '0;
    i_rd_valid = 0; i_rd_lqid = '0; i_rd = '0; i_fflags = '0;
    i_flush = 0; i_lookup_sb_id = '0;
    i_drain_ready = 1; i_cmpl_ready = 1;
  endtask

  task automatic alloc(input int sb, input int lq, input bit first, input bit last,
                       input bit ld, input int vd);
    i_alloc_valid = 1; i_alloc_sb_id = SBW'(sb); i_alloc_lqid = LQW'(lq);
    i_alloc_first = first; i_alloc_last = last; i_alloc_is_load = ld; i_alloc_vd = 5'(vd);
  endtask

  task automatic sync_end(input int sb);
    i_sync_end_valid = 1; i_sync_end_sb_id = SBW'(sb);
  endtask

  task automatic commit(input int lq);
    i_lq_commit_valid = 1; i_lq_commit_lqid = LQW'(lq);
  endtask

  // Compare every output with the model, #1 after inputs change
  task automatic settle();
    bit de[N], ce[N];
    int ls;
    #1;
    for (int e = 0; e < N; e++) begin
      de[e] = m_valid[e] && m_load[e] && m_sync[e] && m_last[e] && !m_drained[e];
      ce[e] = m_valid[e] && m_ref[e] == 0 && m_sync[e] && m_last[e];
    end
    e_d = pick(de, dptr, dhold_v, dhold);
    e_c = pick(ce, cptr, chold_v, chold);
    ls = int'(i_lookup_sb_id);
    chk("drain_valid", 64'(o_drain_valid), 64'(e_d >= 0));
    chk("drain_sb", 64'(o_drain_sb_id), 64'(e_d >= 0 ? e_d : 0));
    chk("drain_ref", 64'(o_drain_ref_count), 64'(e_d >= 0 ? m_ref[e_d] : 0));
    chk("drain_lqs", 64'(o_drain_lqid_start), 64'(e_d >= 0 ? m_lqs[e_d] : 0));
    chk("cmpl_valid", 64'(o_cmpl_valid), 64'(e_c >= 0));
    chk("cmpl_sb", 64'(o_cmpl_sb_id), 64'(e_c >= 0 ? e_c : 0));
    chk("cmpl_rd", o_cmpl_rd, e_c >= 0 ? m_rd[e_c] : 64'd0);
    chk("cmpl_ff", 64'(o_cmpl_fflags), 64'(e_c >= 0 ? m_ff[e_c] : 0));
    chk("lookup_vd", 64'(o_lookup_vd), 64'(m_valid[ls] ? m_vd[ls] : 0));
    chk("lookup_lqid", 64'(o_lookup_lqid), 64'(m_valid[ls] ? m_lqs[ls] : 0));
    chk("err", 64'(o_err), 64'(m_err));
  endtask

  // Clock edge: apply the cycle's events to the model
  task automatic tick();
    int a, cs, rs, n;
    bit dfire, cfire, old_va;
    @(posedge clk);
    if (i_flush) begin
      for (int e = 0; e < N; e++) m_valid[e] = 0;
      dptr = 0; cptr = 0; dhold_v = 0; chold_v = 0;
    end else begin
      a  = int'(i_alloc_sb_id);
      cs = m_map[i_lq_commit_lqid];
      rs = m_map[i_rd_lqid];
      old_va = m_valid[a];
      dfire = e_d >= 0 && i_drain_ready;
      cfire = e_c >= 0 && i_cmpl_ready;
      dhold_v = e_d >= 0 && !i_drain_ready; dhold = e_d;
      chold_v = e_c >= 0 && !i_cmpl_ready;  chold = e_c;
      if (dfire) begin m_drained[e_d] = 1; dptr = (e_d + 1) % N; end
      if (cfire) begin m_valid[e_c] = 0;   cptr = (e_c + 1) % N; end
      if (i_sync_end_valid) m_sync[i_sync_end_sb_id] = 1;
      for (int e = 0; e < N; e++) begin
        n = (i_alloc_valid && i_alloc_first && a == e) ? 0 : m_ref[e];
        n = n + int'(i_alloc_valid && a == e) - int'(i_lq_commit_valid && cs == e);
        if (n < 0)      begin m_err = 1; n = 0; end
        if (n > MAXREF) begin m_err = 1; n = MAXREF; end
        m_ref[e] = n;
      end
      if (i_alloc_valid) begin
        m_map[i_alloc_lqid] = a;
        if (i_alloc_first) begin
          if (old_va) m_err = 1;
          m_valid[a] = 1; m_load[a] = i_alloc_is_load; m_last[a] = i_alloc_last;
          m_sync[a] = i_sync_end_valid && int'(i_sync_end_sb_id) == a;
          m_drained[a] = 0; m_lqs[a] = int'(i_alloc_lqid); m_vd[a] = int'(i_alloc_vd);
          m_rd[a] = '0; m_ff[a] = 0;
        end else if (i_alloc_last) m_last[a] = 1;
      end
      if (i_rd_valid) begin m_rd[rs] = i_rd; m_ff[rs] = int'(i_fflags); end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; idle();
    #1; model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    model_reset();
    @(negedge clk);
    settle();
    chk("reset_drain_valid", 64'(o_drain_valid), 64'd0);
    chk("reset_cmpl_valid", 64'(o_cmpl_valid), 64'd0);
    @(negedge clk);
    reset = 0;

    // ---- single load ----
    idle(); alloc(3, 2, 1, 1, 1, 9); settle(); tick();
    idle(); sync_end(3); i_lookup_sb_id = 3'd3; settle();
    chk("t1_lookup_vd", 64'(o_lookup_vd), 64'd9);
    tick();
    idle(); settle();
    chk("t1_drain_valid", 64'(o_drain_valid), 64'd1);
    chk("t1_drain_sb", 64'(o_drain_sb_id), 64'd3);
    chk("t1_drain_ref", 64'(o_drain_ref_count), 64'd1);
    chk("t1_drain_lqs", 64'(o_drain_lqid_start), 64'd2);
    tick();
    idle(); commit(2); settle(); tick();
    idle(); settle();
    chk("t1_cmpl_valid", 64'(o_cmpl_valid), 64'd1);
    chk("t1_cmpl_sb", 64'(o_cmpl_sb_id), 64'd3);
    tick();
    idle(); settle();
    chk("t1_cmpl_gone", 64'(o_cmpl_valid), 64'd0);
    tick();

    // ---- multi-allocation ----
    do_reset();
    idle(); alloc(5, 0, 1, 0, 1, 4); settle(); tick();
    idle(); alloc(5, 1, 0, 0, 1, 4); settle(); tick();
    idle(); alloc(5, 2, 0, 1, 1, 4); sync_end(5); settle(); tick();
    idle(); commit(0); i_rd_valid = 1; i_rd_lqid = 3'd1; i_rd = 64'hABCD; i_fflags = 5'h04;
    settle();
    chk("t2_drain_sb", 64'(o_drain_sb_id), 64'd5);
    chk("t2_drain_ref", 64'(o_drain_ref_count), 64'd3);
    tick();
    idle(); commit(1); settle(); tick();
    idle(); commit(2); settle();
    chk("t2_not_yet", 64'(o_cmpl_valid), 64'd0);
    tick();
    idle(); settle();
    chk("t2_cmpl_sb", 64'(o_cmpl_sb_id), 64'd5);
    chk("t2_cmpl_rd", o_cmpl_rd, 64'hABCD);
    chk("t2_cmpl_ff", 64'(o_cmpl_fflags), 64'h4);
    tick();

    // ---- completion backpressure and fairness ----
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle(); i_cmpl_ready = 0; alloc(k, k, 1, 1, 0, k); sync_end(k); settle(); tick();
    end
    for (int k = 0; k < 3; k++) begin
      idle(); i_cmpl_ready = 0; commit(k); settle(); tick();
    end
    for (int k = 0; k < 4; k++) begin
      idle(); i_cmpl_ready = 0; settle();
      chk("t3_hold_sb", 64'(o_cmpl_sb_id), 64'd0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      idle(); settle();
      chk("t3_order", 64'(o_cmpl_sb_id), 64'(k));
      tick();
    end
    idle(); settle();
    chk("t3_empty", 64'(o_cmpl_valid), 64'd0);
    tick();

    // ---- same-cycle alloc/commit, underflow error ----
    do_reset();
    idle(); i_drain_ready = 0; i_cmpl_ready = 0; alloc(7, 3, 1, 0, 1, 1); settle(); tick();
    idle(); i_drain_ready = 0; i_cmpl_ready = 0; alloc(7, 4, 0, 1, 1, 1); sync_end(7); settle(); tick();
    idle(); i_drain_ready = 0; i_cmpl_ready = 0; alloc(7, 5, 0, 0, 1, 1); commit(3); settle();
    chk("t4_ref_before", 64'(o_drain_ref_count), 64'd2);
    tick();
    idle(); i_drain_ready = 0; i_cmpl_ready = 0; commit(4); settle();
    chk("t4_ref_same", 64'(o_drain_ref_count), 64'd2);
    chk("t4_no_err", 64'(o_err), 64'd0);
    tick();
    idle(); i_drain_ready = 0; i_cmpl_ready = 0; commit(5); settle(); tick();
    idle(); i_drain_ready = 0; i_cmpl_ready = 0; commit(4); settle();
    chk("t4_zero_cmpl", 64'(o_cmpl_valid), 64'd1);
    tick();
    idle(); i_drain_ready = 0; i_cmpl_ready = 0; settle();
    chk("t4_err", 64'(o_err), 64'd1);
    chk("t4_ref_hold0", 64'(o_drain_ref_count), 64'd0);
    tick();

    // ---- flush while a drain is pending ----
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle(); i_drain_ready = 0; alloc(k, k, 1, 1, 1, k); sync_end(k); settle(); tick();
    end
    idle(); i_drain_ready = 0; settle();
    chk("t5_pending", 64'(o_drain_valid), 64'd1);
    tick();
    idle(); i_drain_ready = 0; i_flush = 1; settle(); tick();
    idle(); settle();
    chk("t5_drain_off", 64'(o_drain_valid), 64'd0);
    chk("t5_cmpl_off", 64'(o_cmpl_valid), 64'd0);
    tick();
    idle(); alloc(0, 0, 1, 1, 1, 2); sync_end(0); settle(); tick();
    idle(); settle();
    chk("t5_realloc", 64'(o_drain_valid), 64'd1);
    chk("t5_realloc_sb", 64'(o_drain_sb_id), 64'd0);
    tick();

    // ---- async reset mid-drain ----
    do_reset();
    idle(); i_drain_ready = 0; i_cmpl_ready = 0; alloc(2, 1, 1, 1, 1, 6); sync_end(2); settle(); tick();
    idle(); i_drain_ready = 0; i_cmpl_ready = 0; alloc(4, 2, 1, 1, 0, 7); sync_end(4); settle(); tick();
    idle(); i_drain_ready = 0; i_cmpl_ready = 0; commit(2); settle(); tick();
    idle(); i_drain_ready = 0; i_cmpl_ready = 0; i_lookup_sb_id = 3'd2; settle();
    chk("t6_pre_drain", 64'(o_drain_valid), 64'd1);
    chk("t6_pre_cmpl", 64'(o_cmpl_valid), 64'd1);
    #2 reset = 1;
    #1;
    chk("t6_rst_drain", 64'(o_drain_valid), 64'd0);
    chk("t6_rst_drain_sb", 64'(o_drain_sb_id), 64'd0);
    chk("t6_rst_cmpl", 64'(o_cmpl_valid), 64'd0);
    chk("t6_rst_lookup", 64'(o_lookup_vd), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      idle(); settle();
      chk("t6_no_cmpl", 64'(o_cmpl_valid), 64'd0);
      tick();
    end
    idle(); alloc(4, 2, 1, 1, 0, 3); sync_end(4); settle(); tick();
    idle(); commit(2); settle(); tick();
    idle(); settle();
    chk("t6_new_cmpl", 64'(o_cmpl_sb_id), 64'd4);
    tick();

    // ---- randomized traffic against the model ----
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      if (it % 300 == 299) do_reset();
      idle();
      i_alloc_valid     = ($urandom_range(0, 9) < 4);
      i_alloc_sb_id     = SBW'($urandom_range(0, N - 1));
      i_alloc_lqid      = LQW'($urandom_range(0, LQD - 1));
      i_alloc_first     = ($urandom_range(0, 9) < 3);
      i_alloc_last      = ($urandom_range(0, 1) == 1);
      i_alloc_is_load   = ($urandom_range(0, 9) < 7);
      i_alloc_vd        = 5'($urandom);
      i_sync_end_valid  = ($urandom_range(0, 9) < 3);
      i_sync_end_sb_id  = SBW'($urandom_range(0, N - 1));
      i_lq_commit_valid = ($urandom_range(0, 9) < 4);
      i_lq_commit_lqid  = LQW'($urandom_range(0, LQD - 1));
      i_rd_valid        = ($urandom_range(0, 9) < 3);
      i_rd_lqid         = LQW'($urandom_range(0, LQD - 1));
      i_rd              = {$urandom, $urandom};
      i_fflags          = 5'($urandom);
      i_flush           = ($urandom_range(0, 99) < 2);
      i_lookup_sb_id    = SBW'($urandom_range(0, N - 1));
      i_drain_ready     = ($urandom_range(0, 9) < 6);
      i_cmpl_ready      = ($urandom_range(0, 9) < 6);
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
